// File: rtl/rob_dual_commit.sv
// Reorder buffer: in-order retire of up to two entries per cycle, with a branch-mispredict flush.
// Commit outputs are registered one cycle after the entry is ready; the decoder is throttled by the combinational full.
module rob_dual_commit #(
    parameter int POS_W  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5,
    parameter int NUM_WB = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    output logic                       flush,
    output logic                       full,
    output logic [POS_W:0]             count,
    input  logic                       decode,
    input  logic [6:0]                 decode_opcode,
    input  logic [REG_W-1:0]           decode_rd,
    input  logic [ADDR_W-1:0]          decode_pc,
    input  logic                       decode_pre_jump,
    input  logic                       decode_is_ready,
    output logic [POS_W-1:0]           decode_nxt_pos,
    input  logic [POS_W-1:0]           decode_rs1_pos,
    input  logic [POS_W-1:0]           decode_rs2_pos,
    output logic                       decode_rs1_ready,
    output logic                       decode_rs2_ready,
    output logic [DATA_W-1:0]          decode_rs1_val,
    output logic [DATA_W-1:0]          decode_rs2_val,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*POS_W-1:0]    wb_pos,
    input  logic [NUM_WB*DATA_W-1:0]   wb_val,
    input  logic [NUM_WB-1:0]          wb_jump,
    input  logic [NUM_WB*ADDR_W-1:0]   wb_pc,
    output logic [1:0]                 cm_valid,
    output logic [2*REG_W-1:0]         cm_rd,
    output logic [2*DATA_W-1:0]        cm_val,
    output logic [2*POS_W-1:0]         cm_pos,
    output logic                       if_set_pc_en,
    output logic [ADDR_W-1:0]          if_set_pc,
    output logic                       if_br,
    output logic                       if_br_jump,
    output logic [ADDR_W-1:0]          if_br_pc,
    output logic                       lsb_commit_store,
    output logic [POS_W-1:0]           lsb_rob_pos
);

    localparam int DEPTH = 2**POS_W;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_L      = 7'b0000011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_ARITHI = 7'b0010011;
    localparam logic [6:0] OP_ARITH  = 7'b0110011;

    typedef struct packed {
        logic              ready;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] val;
        logic [ADDR_W-1:0] pc;
        logic [6:0]        opcode;
        logic              pre_jump;
        logic              is_jump;
        logic [ADDR_W-1:0] nxt_pc;
    } entry_t;

    entry_t           rob [DEPTH];
    logic [POS_W-1:0] head, tail;

    logic [POS_W-1:0] slot_idx [2];
    logic [1:0]       slot_en;
    logic [1:0]       ncommit;
    logic             head_ctrl;
    logic [POS_W+1:0] occ_next;

    logic [1:0]          n_cm_valid;
    logic [2*REG_W-1:0]  n_cm_rd;
    logic [2*DATA_W-1:0] n_cm_val;
    logic [2*POS_W-1:0]  n_cm_pos;
    logic                n_flush, n_set_pc_en, n_br, n_br_jump, n_store;
    logic [ADDR_W-1:0]   n_set_pc, n_br_pc;
    logic [POS_W-1:0]    n_store_pos;

    assign slot_idx[0] = head;
    assign slot_idx[1] = head + 1'b1;

    // Control-flow at head must retire alone so its redirect is not overtaken.
    assign head_ctrl = (rob[head].opcode == OP_JAL) || (rob[head].opcode == OP_JALR) ||
                       (rob[head].opcode == OP_B);

    assign slot_en[0] = (count != '0) && rob[head].ready;
    assign slot_en[1] = slot_en[0] && (count >= (POS_W+1)'(2)) && rob[slot_idx[1]].ready &&
                        !head_ctrl &&
                        !((rob[head].opcode == OP_S) && (rob[slot_idx[1]].opcode == OP_S));

    assign ncommit  = {1'b0, slot_en[0]} + {1'b0, slot_en[1]};
    assign occ_next = {1'b0, count} + (POS_W+2)'(decode) - (POS_W+2)'(ncommit);
    assign full     = (occ_next == (POS_W+2)'(DEPTH));
    assign decode_nxt_pos = tail;

    always_comb begin
        n_cm_valid  = '0;
        n_cm_rd     = '0;
        n_cm_val    = '0;
        n_cm_pos    = '0;
        n_flush     = 1'b0;
        n_set_pc_en = 1'b0;
        n_set_pc    = '0;
        n_br        = 1'b0;
        n_br_jump   = 1'b0;
        n_br_pc     = '0;
        n_store     = 1'b0;
        n_store_pos = '0;
        for (int s = 0; s < 2; s++) begin
            if (slot_en[s]) begin
                n_cm_pos[s*POS_W +: POS_W] = slot_idx[s];
                case (rob[slot_idx[s]].opcode)
                    OP_LUI, OP_AUIPC, OP_ARITH, OP_ARITHI, OP_L: begin
                        n_cm_valid[s]               = 1'b1;
                        n_cm_rd[s*REG_W +: REG_W]   = rob[slot_idx[s]].rd;
                        n_cm_val[s*DATA_W +: DATA_W] = rob[slot_idx[s]].val;
                    end
                    OP_JAL, OP_JALR: begin
                        n_cm_valid[s]               = 1'b1;
                        n_cm_rd[s*REG_W +: REG_W]   = rob[slot_idx[s]].rd;
                        n_cm_val[s*DATA_W +: DATA_W] = rob[slot_idx[s]].val;
                        n_set_pc_en                 = 1'b1;
                        n_set_pc                    = rob[slot_idx[s]].nxt_pc;
                    end
                    OP_B: begin
                        n_br      = 1'b1;
                        n_br_jump = rob[slot_idx[s]].is_jump;
                        n_br_pc   = rob[slot_idx[s]].pc;
                        if (rob[slot_idx[s]].pre_jump != rob[slot_idx[s]].is_jump) begin
                            n_flush     = 1'b1;
                            n_set_pc_en = 1'b1;
                            n_set_pc    = rob[slot_idx[s]].nxt_pc;
                        end
                    end
                    OP_S: begin
                        n_store                      = 1'b1;
                        n_store_pos                  = slot_idx[s];
                        n_cm_valid[s]                = 1'b1;
                        n_cm_val[s*DATA_W +: DATA_W] = rob[slot_idx[s]].val;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Operand lookup sees same-cycle write-backs; the later channel overrides.
    always_comb begin
        decode_rs1_ready = rob[decode_rs1_pos].ready;
        decode_rs1_val   = rob[decode_rs1_pos].val;
        decode_rs2_ready = rob[decode_rs2_pos].ready;
        decode_rs2_val   = rob[decode_rs2_pos].val;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && (wb_pos[k*POS_W +: POS_W] == decode_rs1_pos)) begin
                decode_rs1_ready = 1'b1;
                decode_rs1_val   = wb_val[k*DATA_W +: DATA_W];
            end
            if (wb_valid[k] && (wb_pos[k*POS_W +: POS_W] == decode_rs2_pos)) begin
                decode_rs2_ready = 1'b1;
                decode_rs2_val   = wb_val[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) rob[i] <= '0;
        end else if (rdy) begin
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) rob[i] <= '0;
            end else begin
                if (decode) begin
                    rob[tail] <= '{ready: decode_is_ready, rd: decode_rd, val: '0,
                                   pc: decode_pc, opcode: decode_opcode,
                                   pre_jump: decode_pre_jump, is_jump: 1'b0, nxt_pc: '0};
                end
                for (int k = 0; k < NUM_WB; k++) begin
                    if (wb_valid[k]) begin
                        rob[wb_pos[k*POS_W +: POS_W]].ready   <= 1'b1;
                        rob[wb_pos[k*POS_W +: POS_W]].val     <= wb_val[k*DATA_W +: DATA_W];
                        rob[wb_pos[k*POS_W +: POS_W]].is_jump <= wb_jump[k];
                        rob[wb_pos[k*POS_W +: POS_W]].nxt_pc  <= wb_pc[k*ADDR_W +: ADDR_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0; tail <= '0; count <= '0;
            flush <= 1'b0; cm_valid <= '0; cm_rd <= '0; cm_val <= '0; cm_pos <= '0;
            if_set_pc_en <= 1'b0; if_set_pc <= '0;
            if_br <= 1'b0; if_br_jump <= 1'b0; if_br_pc <= '0;
            lsb_commit_store <= 1'b0; lsb_rob_pos <= '0;
        end else if (rdy) begin
            if (flush) begin
                head <= '0; tail <= '0; count <= '0;
                flush <= 1'b0; cm_valid <= '0; cm_rd <= '0; cm_val <= '0; cm_pos <= '0;
                if_set_pc_en <= 1'b0; if_set_pc <= '0;
                if_br <= 1'b0; if_br_jump <= 1'b0; if_br_pc <= '0;
                lsb_commit_store <= 1'b0; lsb_rob_pos <= '0;
            end else begin
                head  <= head + POS_W'(ncommit);
                tail  <= tail + POS_W'(decode);
                count <= count + (POS_W+1)'(decode) - (POS_W+1)'(ncommit);
                flush            <= n_flush;
                cm_valid         <= n_cm_valid;
                cm_rd            <= n_cm_rd;
                cm_val           <= n_cm_val;
                cm_pos           <= n_cm_pos;
                if_set_pc_en     <= n_set_pc_en;
                if_set_pc        <= n_set_pc;
                if_br            <= n_br;
                if_br_jump       <= n_br_jump;
                if_br_pc         <= n_br_pc;
                lsb_commit_store <= n_store;
                lsb_rob_pos      <= n_store_pos;
            end
        end
    end

endmodule

// File: tb/tb_rob_dual_commit.sv
// Directed bench for rob_dual_commit: inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
module tb_rob_dual_commit;

    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_ARITHI = 7'b0010011;
    localparam logic [6:0] OP_ARITH  = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        flush, full;
    logic [4:0]  count;
    logic        decode, decode_pre_jump, decode_is_ready;
    logic [6:0]  decode_opcode;
    logic [4:0]  decode_rd;
    logic [31:0] decode_pc;
    logic [3:0]  decode_nxt_pos, decode_rs1_pos, decode_rs2_pos;
    logic        decode_rs1_ready, decode_rs2_ready;
    logic [31:0] decode_rs1_val, decode_rs2_val;
    logic [1:0]  wb_valid, wb_jump;
    logic [7:0]  wb_pos;
    logic [63:0] wb_val, wb_pc;
    logic [1:0]  cm_valid;
    logic [9:0]  cm_rd;
    logic [63:0] cm_val;
    logic [7:0]  cm_pos;
    logic        if_set_pc_en, if_br, if_br_jump, lsb_commit_store;
    logic [31:0] if_set_pc, if_br_pc;
    logic [3:0]  lsb_rob_pos;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rob_dual_commit dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .full(full), .count(count),
        .decode(decode), .decode_opcode(decode_opcode), .decode_rd(decode_rd),
        .decode_pc(decode_pc), .decode_pre_jump(decode_pre_jump),
        .decode_is_ready(decode_is_ready), .decode_nxt_pos(decode_nxt_pos),
        .decode_rs1_pos(decode_rs1_pos), .decode_rs2_pos(decode_rs2_pos),
        .decode_rs1_ready(decode_rs1_ready), .decode_rs2_ready(decode_rs2_ready),
        .decode_rs1_val(decode_rs1_val), .decode_rs2_val(decode_rs2_val),
        .wb_valid(wb_valid), .wb_pos(wb_pos), .wb_val(wb_val), .wb_jump(wb_jump),
        .wb_pc(wb_pc), .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_val(cm_val),
        .cm_pos(cm_pos), .if_set_pc_en(if_set_pc_en), .if_set_pc(if_set_pc),
        .if_br(if_br), .if_br_jump(if_br_jump), .if_br_pc(if_br_pc),
        .lsb_commit_store(lsb_commit_store), .lsb_rob_pos(lsb_rob_pos)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle();
        decode = 1'b0; decode_opcode = '0; decode_rd = '0; decode_pc = '0;
        decode_pre_jump = 1'b0; decode_is_ready = 1'b0;
        decode_rs1_pos = '0; decode_rs2_pos = '0;
        wb_valid = '0; wb_pos = '0; wb_val = '0; wb_jump = '0; wb_pc = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] pc,
                         input logic pj, input logic is_rdy);
        decode = 1'b1; decode_opcode = op; decode_rd = rd; decode_pc = pc;
        decode_pre_jump = pj; decode_is_ready = is_rdy;
    endtask

    task automatic wb(input int ch, input logic [3:0] pos, input logic [31:0] val,
                      input logic j, input logic [31:0] pc);
        wb_valid[ch]          = 1'b1;
        wb_pos[ch*4 +: 4]     = pos;
        wb_val[ch*32 +: 32]   = val;
        wb_jump[ch]           = j;
        wb_pc[ch*32 +: 32]    = pc;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_cm_valid", cm_valid, 0);
        check("rst_flush", flush, 0);
        check("rst_full", full, 0);
        check("rst_nxt_pos", decode_nxt_pos, 0);
        @(posedge clk); #1; rst = 1'b1;

        // single ARITH, result two cycles after write-back
        issue(OP_ARITH, 5'd3, 32'h0, 1'b0, 1'b0); tick();
        wb(0, 4'd0, 32'h55, 1'b0, 32'h0); tick();
        @(negedge clk); check("t1_no_early_commit", cm_valid, 0); tick();
        @(negedge clk);
        check("t1_cm_valid", cm_valid, 2'b01);
        check("t1_cm_rd", cm_rd, 10'd3);
        check("t1_cm_val", cm_val, 64'h55);
        check("t1_count", count, 0);
        tick(); @(negedge clk); check("t1_pulse_clear", cm_valid, 0);

        // dual ARITHI commit
        issue(OP_ARITHI, 5'd1, 32'h4, 1'b0, 1'b0); tick();
        issue(OP_ARITHI, 5'd2, 32'h8, 1'b0, 1'b1);
        wb(0, 4'd1, 32'h11, 1'b0, 32'h0); tick();
        @(negedge clk); check("t2_count2", count, 2); tick();
        @(negedge clk);
        check("t2_cm_valid", cm_valid, 2'b11);
        check("t2_cm_rd", cm_rd, 10'h041);
        check("t2_cm_val", cm_val, 64'h11);
        check("t2_cm_pos", cm_pos, 8'h21);
        check("t2_count0", count, 0);

        // two stores retire one per cycle
        issue(OP_S, 5'd7, 32'h10, 1'b0, 1'b0); tick();
        issue(OP_S, 5'd8, 32'h14, 1'b0, 1'b0); tick();
        wb(0, 4'd3, 32'h33, 1'b0, 32'h0); wb(1, 4'd4, 32'h44, 1'b0, 32'h0); tick();
        tick();
        @(negedge clk);
        check("t2_st0_store", lsb_commit_store, 1);
        check("t2_st0_pos", lsb_rob_pos, 3);
        check("t2_st0_cm_valid", cm_valid, 2'b01);
        check("t2_st0_cm_rd", cm_rd, 0);
        check("t2_st0_count", count, 1);
        tick(); @(negedge clk);
        check("t2_st1_store", lsb_commit_store, 1);
        check("t2_st1_pos", lsb_rob_pos, 4);
        check("t2_st1_count", count, 0);
        tick(); @(negedge clk);
        check("t2_st_clear", lsb_commit_store, 0);

        // mispredicted branch
        issue(OP_B, 5'd0, 32'h40, 1'b0, 1'b0); tick();
        wb(0, 4'd5, 32'h0, 1'b1, 32'h100); tick();
        tick();
        @(negedge clk);
        check("t3_if_br", if_br, 1);
        check("t3_br_jump", if_br_jump, 1);
        check("t3_br_pc", if_br_pc, 32'h40);
        check("t3_flush", flush, 1);
        check("t3_set_pc_en", if_set_pc_en, 1);
        check("t3_set_pc", if_set_pc, 32'h100);
        check("t3_cm_valid", cm_valid, 0);
        issue(OP_ARITH, 5'd9, 32'h0, 1'b0, 1'b1);
        tick(); @(negedge clk);
        check("t3_count", count, 0);
        check("t3_nxt_pos", decode_nxt_pos, 0);
        check("t3_flush_clear", flush, 0);
        check("t3_br_clear", if_br, 0);

        // fill to full, then wrap
        for (int i = 0; i < 16; i++) begin
            issue(OP_ARITH, 5'(i), 32'(i), 1'b0, 1'b0);
            if (i == 14) begin @(negedge clk); check("t4_not_full15", full, 0); end
            if (i == 15) begin @(negedge clk); check("t4_full16", full, 1); end
            tick();
        end
        @(negedge clk);
        check("t4_count16", count, 16);
        wb(0, 4'd0, 32'hA0, 1'b0, 32'h0); tick();
        issue(OP_ARITH, 5'd20, 32'h200, 1'b0, 1'b0);
        @(negedge clk); check("t4_full_swap", full, 1);
        tick(); @(negedge clk);
        check("t4_swap_count", count, 16);
        check("t4_swap_cm_val", cm_val, 64'hA0);
        check("t4_swap_cm_valid", cm_valid, 2'b01);
        check("t4_swap_nxt", decode_nxt_pos, 1);
        for (int i = 1; i < 15; i++) begin
            wb(0, 4'(i), 32'(32'hA0 + i), 1'b0, 32'h0);
            tick();
        end
        tick();
        @(negedge clk); check("t4_drain_count", count, 2);
        wb(0, 4'd15, 32'hAF, 1'b0, 32'h0); wb(1, 4'd0, 32'hB0, 1'b0, 32'h0); tick();
        tick(); @(negedge clk);
        check("t4_wrap_valid", cm_valid, 2'b11);
        check("t4_wrap_pos", cm_pos, 8'h0F);
        check("t4_wrap_val", cm_val, {32'hB0, 32'hAF});
        check("t4_wrap_rd", cm_rd, 10'h28F);
        check("t4_wrap_count", count, 0);

        // lookup with bypass
        decode_rs1_pos = 4'd5; decode_rs2_pos = 4'd6;
        wb(0, 4'd5, 32'h11, 1'b0, 32'h0); wb(1, 4'd5, 32'hAB, 1'b0, 32'h0);
        @(negedge clk);
        check("t5_rs1_ready", decode_rs1_ready, 1);
        check("t5_rs1_val", decode_rs1_val, 32'hAB);
        check("t5_rs2_ready", decode_rs2_ready, 1);
        check("t5_rs2_val", decode_rs2_val, 32'hA6);
        tick();
        decode_rs1_pos = 4'd5;
        @(negedge clk);
        check("t5_stored_val", decode_rs1_val, 32'hAB);

        // freeze, then asynchronous reset mid-stream
        tick();
        for (int i = 0; i < 6; i++) begin
            issue(OP_ARITH, 5'(10 + i), 32'(i), 1'b0, 1'b0); tick();
        end
        wb(0, 4'd1, 32'hC1, 1'b0, 32'h0); wb(1, 4'd2, 32'hC2, 1'b0, 32'h0); tick();
        tick(); @(negedge clk);
        check("t6_cm_valid", cm_valid, 2'b11);
        check("t6_count", count, 4);
        rdy = 1'b0;
        tick(); @(negedge clk);
        check("t6_hold_valid", cm_valid, 2'b11);
        check("t6_hold_count", count, 4);
        #1 rst = 1'b0;
        #1;
        check("t6_rst_valid", cm_valid, 0);
        check("t6_rst_count", count, 0);
        check("t6_rst_val", cm_val, 0);
        check("t6_rst_nxt", decode_nxt_pos, 0);
        rdy = 1'b1;
        @(posedge clk); #3 rst = 1'b1;
        @(negedge clk);
        check("t6_after_count", count, 0);
        check("t6_after_valid", cm_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
